// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Shared types and constants for the multicycle MIPS main
//                control FSM: state encoding, opcodes, ALU-op codes, mux
//                select codes and the packed control word handed from the
//                output decoder to the top level.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU decoder operation codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU source B selects
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Raw Moore control word for one state, before reset / handshake gating.
    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_word_t;

    localparam int CTRL_W = $bits(ctrl_word_t);

    // States whose exit to FETCH completes (retires) an instruction.
    function automatic logic is_retire_state(input state_t s);
        return (s == S_MEMWB)  || (s == S_MEMWRITE) || (s == S_ALUWB) ||
               (s == S_BRANCH) || (s == S_ADDIWB)   || (s == S_JUMP);
    endfunction

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_outdec
//  Description : Purely combinational state -> control-word decode for the
//                multicycle MIPS main controller. Produces the ungated Moore
//                control word; handshake and reset gating live in the top.
//  Ports       : i_state - current FSM state encoding (4 bits)
//                o_ctrl  - packed control word (see ctrl_word_t)
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]        i_state,
    output logic [CTRL_W-1:0] o_ctrl
);

    ctrl_word_t w_cw;

    always_comb begin
        w_cw = '0;
        case (state_t'(i_state))
            S_FETCH: begin
                w_cw.ir_write  = 1'b1;
                w_cw.pc_write  = 1'b1;
                w_cw.alu_src_b = SRCB_FOUR;
                w_cw.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                // Precompute the branch target while registers are read.
                w_cw.alu_src_b = SRCB_IMM_SH2;
                w_cw.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                w_cw.alu_src_a = 1'b1;
                w_cw.alu_src_b = SRCB_IMM;
                w_cw.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                w_cw.iord = 1'b1;
            end
            S_MEMWB: begin
                w_cw.reg_dst    = 1'b0;
                w_cw.mem_to_reg = 1'b1;
                w_cw.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_cw.iord      = 1'b1;
                w_cw.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                w_cw.alu_src_a = 1'b1;
                w_cw.alu_src_b = SRCB_REG;
                w_cw.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_cw.reg_dst    = 1'b1;
                w_cw.mem_to_reg = 1'b0;
                w_cw.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                w_cw.alu_src_a = 1'b1;
                w_cw.alu_src_b = SRCB_REG;
                w_cw.alu_op    = ALUOP_SUB;
                w_cw.pc_src    = PCSRC_ALUOUT;
                w_cw.branch    = 1'b1;
            end
            S_ADDIEX: begin
                w_cw.alu_src_a = 1'b1;
                w_cw.alu_src_b = SRCB_IMM;
                w_cw.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                w_cw.reg_dst    = 1'b0;
                w_cw.mem_to_reg = 1'b0;
                w_cw.reg_write  = 1'b1;
            end
            S_JUMP: begin
                w_cw.pc_src   = PCSRC_JUMP;
                w_cw.pc_write = 1'b1;
            end
            default: begin
                // ILLEGAL and unused encodings drive nothing.
                w_cw = '0;
            end
        endcase
    end

    assign o_ctrl = w_cw;

endmodule : mips_ctrl_outdec
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Main control FSM for the multicycle MIPS datapath. Decodes
//                the opcode, sequences fetch/decode/execute/memory/writeback,
//                waits on the memory-ready handshake, flags illegal opcodes
//                (sticky) and counts retired instructions.
//  Ports       : clk, rst_n (sync, active-low)
//                opcode, zero, mem_ready           - inputs
//                ir_write, pc_en, iord, mem_write,
//                reg_write, reg_dst, mem_to_reg,
//                alu_src_a, alu_src_b, pc_src,
//                alu_op                            - datapath controls
//                illegal_op, instr_count           - status
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    state_t           w_next;
    ctrl_word_t       w_cw;
    logic             w_fetch_ok;
    logic             w_retire;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                // Only lw/sw reach here; anything else falls back to fetch.
                if (opcode == OP_LW) begin
                    w_next = S_MEMREAD;
                end else if (opcode == OP_SW) begin
                    w_next = S_MEMWRITE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_ADDIEX:   w_next = S_ADDIWB;
            S_ADDIWB:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_ILLEGAL:  w_next = S_FETCH;
            default:    w_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore control word
    // ------------------------------------------------------------------
    mips_ctrl_outdec u_outdec (
        .i_state (r_state),
        .o_ctrl  (w_cw)
    );

    // ir_write/pc_write in FETCH only fire once the instruction word arrives.
    assign w_fetch_ok = (r_state != S_FETCH) || mem_ready;

    // ------------------------------------------------------------------
    // Retired-instruction counter and sticky illegal flag
    // ------------------------------------------------------------------
    assign w_retire = is_retire_state(r_state) && (w_next == S_FETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_retire) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (r_state == S_ILLEGAL) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output gating: everything forced low while reset is asserted so no
    // partial write can happen during an abandoned instruction.
    // ------------------------------------------------------------------
    assign ir_write    = rst_n & w_cw.ir_write & w_fetch_ok;
    assign pc_en       = rst_n & ((w_cw.pc_write & w_fetch_ok) | (w_cw.branch & zero));
    assign iord        = rst_n & w_cw.iord;
    assign mem_write   = rst_n & w_cw.mem_write;
    assign reg_write   = rst_n & w_cw.reg_write;
    assign reg_dst     = rst_n & w_cw.reg_dst;
    assign mem_to_reg  = rst_n & w_cw.mem_to_reg;
    assign alu_src_a   = rst_n & w_cw.alu_src_a;
    assign alu_src_b   = rst_n ? w_cw.alu_src_b : 2'b00;
    assign pc_src      = rst_n ? w_cw.pc_src    : 2'b00;
    assign alu_op      = rst_n ? w_cw.alu_op    : 2'b00;
    assign illegal_op  = r_illegal;
    assign instr_count = r_count;

endmodule : mips_multicycle_ctrl
`default_nettype wire
